mux3_rr_arbiter: RTL

- Round-robin arbiter that shares one 3-input datapath mux between three requesters.
- Produces one-hot grants plus the matching 2-bit select for the shared 3:1 mux (00 = input_a, 01 = input_b, 10 = input_c).
- Sits beside the mux in the datapath. Owners hold the resource for as long as they keep their request asserted.
- An optional timeout preempts an owner that holds the resource too long.

---
 rtl/mux3_rr_arbiter_if.sv | 11 +
 rtl/mux3_rr_arbiter.sv | 132 +++++++++++++
 2 files changed

// File: rtl/mux3_rr_arbiter_if.sv
// Request/grant bundle between three requesters and the shared 3:1 mux arbiter.
interface mux3_rr_arbiter_if;
  logic [2:0] req;
  logic [2:0] grant;
  logic [1:0] select;
  logic       busy;
  logic       preempted;

  modport master (output req, input grant, select, busy, preempted);
  modport slave  (input req, output grant, select, busy, preempted);
endinterface

// File: rtl/mux3_rr_arbiter.sv
// Round-robin owner arbiter for a shared 3:1 datapath mux.
// Define MUX3_ARB_TIMEOUT_EN to add hold-time preemption with per-requester masking.
module mux3_rr_arbiter #(
  parameter int unsigned HOLD_MAX = 8,
  parameter int unsigned CNT_W    = 8
) (
  input  logic                     clk,
  input  logic                     arst_n,
  mux3_rr_arbiter_if.slave         bus
);

  if (HOLD_MAX < 32'd1 || HOLD_MAX > 32'd255 || HOLD_MAX >= (32'd1 << CNT_W)) begin : g_bad_cfg
    $error("mux3_rr_arbiter: illegal HOLD_MAX/CNT_W combination");
  end

  typedef enum logic [0:0] {IDLE, OWNED} state_t;

  state_t      state, state_nxt;
  logic [2:0]  grant_r, grant_nxt;
  logic [1:0]  select_r, select_nxt;
  logic        busy_r, busy_nxt;
  logic        pre_r, pre_nxt;
  logic [1:0]  last_owner, last_nxt;
  logic [2:0]  mask;
  logic [2:0]  eligible;
  logic [1:0]  winner;

`ifdef MUX3_ARB_TIMEOUT_EN
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_MAX - 32'd1);
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [2:0]       mask_nxt;
`else
  assign mask = 3'b000;
`endif

  // First eligible index in the order last+1, last+2, last (mod 3).
  function automatic logic [1:0] rr_pick(input logic [2:0] elig, input logic [1:0] last);
    logic [1:0] p0, p1, p2;
    case (last)
      2'd0:    begin p0 = 2'd1; p1 = 2'd2; p2 = 2'd0; end
      2'd1:    begin p0 = 2'd2; p1 = 2'd0; p2 = 2'd1; end
      default: begin p0 = 2'd0; p1 = 2'd1; p2 = 2'd2; end
    endcase
    if (elig[p0])      rr_pick = p0;
    else if (elig[p1]) rr_pick = p1;
    else               rr_pick = p2;
  endfunction

  assign eligible = bus.req & ~mask;
  assign winner   = rr_pick(eligible, last_owner);

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state      <= IDLE;
      grant_r    <= 3'b000;
      select_r   <= 2'd0;
      busy_r     <= 1'b0;
      pre_r      <= 1'b0;
      last_owner <= 2'd2;
`ifdef MUX3_ARB_TIMEOUT_EN
      cnt        <= '0;
      mask       <= 3'b000;
`endif
    end else begin
      state      <= state_nxt;
      grant_r    <= grant_nxt;
      select_r   <= select_nxt;
      busy_r     <= busy_nxt;
      pre_r      <= pre_nxt;
      last_owner <= last_nxt;
`ifdef MUX3_ARB_TIMEOUT_EN
      cnt        <= cnt_nxt;
      mask       <= mask_nxt;
`endif
    end
  end

  always_comb begin
    state_nxt  = state;
    grant_nxt  = grant_r;
    select_nxt = select_r;
    last_nxt   = last_owner;
    pre_nxt    = 1'b0;
`ifdef MUX3_ARB_TIMEOUT_EN
    cnt_nxt    = cnt;
    // A masked requester becomes eligible again once it drops its request.
    mask_nxt   = mask & bus.req;
`endif
    case (state)
      IDLE: begin
        if (|eligible) begin
          state_nxt  = OWNED;
          grant_nxt  = 3'b001 << winner;
          select_nxt = winner;
          last_nxt   = winner;
`ifdef MUX3_ARB_TIMEOUT_EN
          cnt_nxt    = '0;
`endif
        end
      end
      OWNED: begin
        // Any release, voluntary or forced, passes through one idle cycle; select is held.
        if (bus.req[select_r]) begin
`ifdef MUX3_ARB_TIMEOUT_EN
          if (cnt == HOLD_LAST) begin
            state_nxt          = IDLE;
            grant_nxt          = 3'b000;
            pre_nxt            = 1'b1;
            mask_nxt[select_r] = 1'b1;
          end else if (cnt != '1) begin
            cnt_nxt = cnt + CNT_W'(1);
          end
`endif
        end else begin
          state_nxt = IDLE;
          grant_nxt = 3'b000;
        end
      end
      default: begin
        state_nxt = IDLE;
        grant_nxt = 3'b000;
      end
    endcase
    busy_nxt = |grant_nxt;
  end

  assign bus.grant     = grant_r;
  assign bus.select    = select_r;
  assign bus.busy      = busy_r;
  assign bus.preempted = pre_r;

endmodule
